// File: rtl/cook_countdown_if.sv
// Control/status bundle between the cook-time setting block, the user
// buttons and the countdown stage.
interface cook_countdown_if;
  logic       start;
  logic       stop;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic [5:0] min_left;
  logic [5:0] sec_left;
  logic       running;
  logic       done;
  logic       alarm;
  logic       setup_en;

  // Driver side: buttons and setting block, observing the countdown.
  modport master (
    output start, stop, set_min, set_sec,
    input  min_left, sec_left, running, done, alarm, setup_en
  );

  // Countdown stage.
  modport slave (
    input  start, stop, set_min, set_sec,
    output min_left, sec_left, running, done, alarm, setup_en
  );
endinterface

// File: rtl/cook_countdown.sv
// Cook-time countdown: loads clamped min/sec on start, counts down once per
// CLK_HZ cycles, supports pause/resume/cancel, then sounds the alarm for
// ALARM_SEC seconds before returning to idle.
module cook_countdown #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned MAX_MIN   = 5,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic            clk,
  input  logic            reset,
  cook_countdown_if.slave ctl
);

  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
  localparam logic [5:0]    MIN_LIMIT  = 6'(MAX_MIN);
  localparam logic [5:0]    SEC_LIMIT  = 6'd59;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    min_left_q, min_left_d;
  logic [5:0]    sec_left_q, sec_left_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          running_q, done_q, alarm_q, setup_en_q;

  logic [5:0]    ld_min, ld_sec;
  logic          ld_zero;
  logic          tick;
  logic [TW-1:0] tick_nxt;

  // Clamp the requested time and derive the one-second tick.
  always_comb begin
    ld_min   = (ctl.set_min > MIN_LIMIT) ? MIN_LIMIT : ctl.set_min;
    ld_sec   = (ctl.set_sec > SEC_LIMIT) ? SEC_LIMIT : ctl.set_sec;
    ld_zero  = (ld_min == '0) && (ld_sec == '0);
    tick     = (tick_cnt_q == TICK_LAST);
    tick_nxt = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Next-state and counter logic; stop always takes precedence over start.
  always_comb begin
    state_d     = state_q;
    min_left_d  = min_left_q;
    sec_left_d  = sec_left_q;
    tick_cnt_d  = tick_cnt_q;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      IDLE: begin
        min_left_d  = ld_min;
        sec_left_d  = ld_sec;
        tick_cnt_d  = '0;
        alarm_cnt_d = '0;
        if (!ctl.stop && ctl.start && !ld_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ctl.stop) begin
          state_d = PAUSE;
        end else begin
          tick_cnt_d = tick_nxt;
          if (tick) begin
            if (sec_left_q != '0) begin
              sec_left_d = sec_left_q - 1'b1;
            end else if (min_left_q != '0) begin
              min_left_d = min_left_q - 1'b1;
              sec_left_d = SEC_LIMIT;
            end
            // This tick lands on 0:00 (0:00 itself is unreachable but safe).
            if ((min_left_q == '0) && (sec_left_q <= 6'd1)) begin
              state_d     = DONE;
              alarm_cnt_d = '0;
              tick_cnt_d  = '0;
            end
          end
        end
      end
      PAUSE: begin
        if (ctl.stop) begin
          state_d = IDLE;
        end else if (ctl.start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (ctl.start || ctl.stop) begin
          state_d = IDLE;
        end else begin
          tick_cnt_d = tick_nxt;
          if (tick) begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_d = IDLE;
            end else begin
              alarm_cnt_d = alarm_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      min_left_q  <= '0;
      sec_left_q  <= '0;
      tick_cnt_q  <= '0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      setup_en_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      min_left_q  <= min_left_d;
      sec_left_q  <= sec_left_d;
      tick_cnt_q  <= tick_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= (state_d == RUN);
      done_q      <= (state_d == DONE);
      alarm_q     <= (state_d == DONE);
      setup_en_q  <= (state_d == IDLE);
    end
  end

  assign ctl.min_left = min_left_q;
  assign ctl.sec_left = sec_left_q;
  assign ctl.running  = running_q;
  assign ctl.done     = done_q;
  assign ctl.alarm    = alarm_q;
  assign ctl.setup_en = setup_en_q;

endmodule

// File: doc/cook_countdown.md
Name: cook_countdown

Overview:
Countdown stage directly downstream of the cook-time setting block. Loads the selected minutes/seconds on start and counts down once per second from the system clock. Supports pause, resume and cancel, and drives the done/alarm indication. While idle it grants the setting block permission to edit the time.

Parameters:
CLK_HZ, 100000000, clock cycles per one-second tick; tick counter width is $clog2(CLK_HZ).
MAX_MIN, 5, largest loadable minute value; must match the setting block.
ALARM_SEC, 10, alarm duration in seconds before automatic return to IDLE.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high.
start  in  1  single-cycle pulse, debounced upstream; start or resume.
stop  in  1  single-cycle pulse, debounced upstream; pause, cancel or acknowledge.
set_min  in  6  minutes from the setting block.
set_sec  in  6  seconds from the setting block.
min_left  out  6  remaining minutes, registered.
sec_left  out  6  remaining seconds, registered.
running  out  1  high only in RUN.
done  out  1  high only in DONE.
alarm  out  1  buzzer/LED drive.
setup_en  out  1  high only in IDLE; connects to the setting block's enable.

Behaviour:
- Reset (reset=1 at a clock edge) applies in any state and overrides all other inputs.
  - state=IDLE, min_left=0, sec_left=0, tick_cnt=0, alarm_cnt=0.
  - running=0, done=0, alarm=0, setup_en=1.
- Load value is clamped: ld_min = min(set_min, MAX_MIN), ld_sec = min(set_sec, 59).
- States are IDLE, RUN, PAUSE and DONE.
- Priority: when start and stop are asserted in the same cycle, stop wins in every state.
- IDLE:
  - Each cycle, min_left/sec_left <= ld_min/ld_sec (1-cycle latency).
  - start with ld_min/ld_sec nonzero -> RUN; values load; tick_cnt <= 0.
  - start with 0:00 -> stay IDLE.
  - stop -> no effect.
- RUN:
  - tick_cnt counts 0..CLK_HZ-1 and wraps to 0; tick = (tick_cnt == CLK_HZ-1).
  - On tick, if sec_left > 0: sec_left decrements.
  - On tick, if sec_left = 0 and min_left > 0: min_left decrements and sec_left <= 59.
  - On the tick where the result is 0:00, go to DONE in the same edge; alarm_cnt <= 0; tick_cnt <= 0.
  - stop -> PAUSE; values and tick_cnt hold.
  - start -> ignored.
- PAUSE:
  - All counters are frozen.
  - start -> RUN, resuming from the held tick_cnt with no restart of the partial second.
  - stop -> IDLE (cancel); outputs reload from set inputs on the next cycle.
- DONE:
  - done=1 and alarm=1; min_left/sec_left hold 0:00.
  - tick_cnt keeps running; alarm_cnt increments on each tick.
  - When alarm_cnt reaches ALARM_SEC-1 on a tick -> IDLE.
  - start or stop -> IDLE immediately (acknowledge).
- Output decode is registered or decoded from the state register; no combinational path from start/stop to any output.
- Arithmetic is 6-bit unsigned with no underflow: decrement happens only when the operand is nonzero.

Test Plan:
1. CLK_HZ=4, ALARM_SEC=2; reset, set 0:05, pulse start -> running=1, 0:04 after 4 cycles; 0:00 with done=1, alarm=1 after 20 cycles; IDLE with setup_en=1 after 8 more cycles.
2. Borrow: set 1:00, start -> 0:59 after 4 cycles; 0:58 after 4 more.
3. Pause/resume: stop when tick_cnt=2 at 0:03 -> frozen for 10 cycles; start -> 0:02 exactly 2 cycles later; then stop, stop -> IDLE, outputs equal set inputs next cycle.
4. Start at 0:00 -> stays IDLE. start+stop in the same cycle in IDLE, RUN and PAUSE -> IDLE, PAUSE and IDLE respectively.
5. Assert reset mid-RUN at 2:17 and mid-DONE -> next edge min_left=0, sec_left=0, running=0, done=0, alarm=0, setup_en=1.
6. Clamp: MAX_MIN=5, set_min=7, set_sec=62, start -> loads 5:59; first tick -> 5:58.
